// File: rtl/lp_pkg.sv
// Shared LP datapath types: Q16.16 entries, sequencer state and ratio-test result codes.
package lp_pkg;

    localparam int unsigned LP_DATA_W = 32;
    localparam int unsigned LP_IDX_W  = 10;

    typedef logic signed [LP_DATA_W-1:0] q16_16_t;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_FINISH = 2'd2
    } lp_state_e;

    typedef enum logic [1:0] {
        RES_NONE = 2'd0,
        RES_CONT = 2'd1,
        RES_TERM = 2'd2,
        RES_ERR  = 2'd3
    } lp_result_e;

endpackage

// File: rtl/ratio_cmp_stage.sv
// Stage 2 of the ratio test: cross-multiplied compare against the running minimum ratio.
module ratio_cmp_stage
    import lp_pkg::*;
#(
    parameter int unsigned DATA_W = LP_DATA_W,
    parameter int unsigned IDX_W  = LP_IDX_W
) (
    input  logic                     aclk,
    input  logic                     aresetn,
    input  logic                     clear,
    input  logic                     valid_in,
    input  logic                     eligible,
    input  logic signed [DATA_W-1:0] b_in,
    input  logic signed [DATA_W-1:0] a_in,
    input  logic [IDX_W-1:0]         idx_in,
    output logic                     min_found_c,
    output logic [IDX_W-1:0]         min_idx_c
);

    localparam int unsigned PROD_W = 2 * DATA_W;

    logic                     found_q,   found_d;
    logic signed [DATA_W-1:0] min_b_q,   min_b_d;
    logic signed [DATA_W-1:0] min_a_q,   min_a_d;
    logic [IDX_W-1:0]         min_idx_q, min_idx_d;

    logic signed [PROD_W-1:0] lhs_c;
    logic signed [PROD_W-1:0] rhs_c;
    logic                     better_c;

    // b_i/a_i < b_min/a_min with both denominators positive; strict so ties keep the lower row
    always_comb begin
        lhs_c     = PROD_W'(b_in) * PROD_W'(min_a_q);
        rhs_c     = PROD_W'(min_b_q) * PROD_W'(a_in);
        better_c  = eligible && (!found_q || (lhs_c < rhs_c));

        found_d   = found_q;
        min_b_d   = min_b_q;
        min_a_d   = min_a_q;
        min_idx_d = min_idx_q;

        if (clear) begin
            found_d   = 1'b0;
            min_b_d   = '0;
            min_a_d   = '0;
            min_idx_d = '0;
        end else if (valid_in && better_c) begin
            found_d   = 1'b1;
            min_b_d   = b_in;
            min_a_d   = a_in;
            min_idx_d = idx_in;
        end

        min_found_c = found_d;
        min_idx_c   = min_idx_d;
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            found_q   <= 1'b0;
            min_b_q   <= '0;
            min_a_q   <= '0;
            min_idx_q <= '0;
        end else begin
            found_q   <= found_d;
            min_b_q   <= min_b_d;
            min_a_q   <= min_a_d;
            min_idx_q <= min_idx_d;
        end
    end

endmodule

// File: rtl/pivot_row_ratio_ctrl.sv
// Simplex pivot-row selection: lock-stepped RHS / pivot-column streams, min-ratio search,
// and a one-cycle result pulse to the LP sequencer.
module pivot_row_ratio_ctrl
    import lp_pkg::*;
#(
    parameter int unsigned              DATA_W = LP_DATA_W,
    parameter int unsigned              IDX_W  = LP_IDX_W,
    parameter logic signed [DATA_W-1:0] EPS    = DATA_W'(1)
) (
    input  logic              aclk,
    input  logic              aresetn,
    input  logic              start,
    input  logic              halt,
    input  logic [DATA_W-1:0] rhs_s_axis_tdata,
    input  logic              rhs_s_axis_tlast,
    input  logic              rhs_s_axis_tvalid,
    output logic              rhs_s_axis_tready,
    input  logic [DATA_W-1:0] pivot_col_s_axis_tdata,
    input  logic              pivot_col_s_axis_tlast,
    input  logic              pivot_col_s_axis_tvalid,
    output logic              pivot_col_s_axis_tready,
    output logic              busy,
    output logic              done,
    output logic              op_continue,
    output logic              terminate,
    output logic              error,
    output logic [IDX_W-1:0]  pivot_row_idx
);

    lp_state_e                state_q, state_d;
    logic [IDX_W-1:0]         row_cnt_q, row_cnt_d;
    logic                     err_q, err_d;

    logic                     s1_valid_q, s1_valid_d;
    logic                     s1_elig_q,  s1_elig_d;
    logic signed [DATA_W-1:0] s1_b_q, s1_b_d;
    logic signed [DATA_W-1:0] s1_a_q, s1_a_d;
    logic [IDX_W-1:0]         s1_idx_q, s1_idx_d;

    logic                     busy_q, busy_d;
    logic                     done_q, done_d;
    logic                     op_continue_q, op_continue_d;
    logic                     terminate_q, terminate_d;
    logic                     error_q, error_d;
    logic [IDX_W-1:0]         pivot_row_idx_q, pivot_row_idx_d;

    logic                     hs_c;
    logic                     clear_c;
    logic                     last_bad_c;
    lp_result_e               result_c;
    logic                     min_found_c;
    logic [IDX_W-1:0]         min_idx_c;

    // Both streams advance together; halt drops ready in the same cycle
    assign hs_c = (state_q == ST_RUN) && rhs_s_axis_tvalid && pivot_col_s_axis_tvalid && !halt;
    assign rhs_s_axis_tready       = hs_c;
    assign pivot_col_s_axis_tready = hs_c;

    always_comb begin
        state_d    = state_q;
        row_cnt_d  = row_cnt_q;
        err_d      = err_q;
        clear_c    = 1'b0;
        result_c   = RES_NONE;
        last_bad_c = (rhs_s_axis_tlast != pivot_col_s_axis_tlast)
                   || (!rhs_s_axis_tlast && (row_cnt_q == {IDX_W{1'b1}}));

        s1_valid_d = hs_c;
        s1_elig_d  = s1_elig_q;
        s1_b_d     = s1_b_q;
        s1_a_d     = s1_a_q;
        s1_idx_d   = s1_idx_q;
        if (hs_c) begin
            s1_b_d    = $signed(rhs_s_axis_tdata);
            s1_a_d    = $signed(pivot_col_s_axis_tdata);
            s1_idx_d  = row_cnt_q;
            s1_elig_d = ($signed(pivot_col_s_axis_tdata) > EPS);
        end

        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d   = ST_RUN;
                    row_cnt_d = '0;
                    err_d     = 1'b0;
                    clear_c   = 1'b1;
                end
            end
            ST_RUN: begin
                if (hs_c) begin
                    row_cnt_d = row_cnt_q + IDX_W'(1);
                    if (last_bad_c) begin
                        err_d   = 1'b1;
                        state_d = ST_FINISH;
                    end else if (rhs_s_axis_tlast) begin
                        state_d = ST_FINISH;
                    end
                end
            end
            ST_FINISH: begin
                state_d = ST_IDLE;
                if (err_q) begin
                    result_c = RES_ERR;
                end else if (min_found_c) begin
                    result_c = RES_CONT;
                end else begin
                    result_c = RES_TERM;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (halt) begin
            state_d  = ST_IDLE;
            clear_c  = 1'b0;
            result_c = RES_NONE;
        end

        busy_d          = (state_d != ST_IDLE);
        done_d          = (result_c != RES_NONE);
        op_continue_d   = (result_c == RES_CONT);
        terminate_d     = (result_c == RES_TERM);
        error_d         = (result_c == RES_ERR);
        pivot_row_idx_d = pivot_row_idx_q;
        if (result_c == RES_CONT) begin
            pivot_row_idx_d = min_idx_c;
        end else if (result_c == RES_TERM) begin
            pivot_row_idx_d = '0;
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q         <= ST_IDLE;
            row_cnt_q       <= '0;
            err_q           <= 1'b0;
            s1_valid_q      <= 1'b0;
            s1_elig_q       <= 1'b0;
            s1_b_q          <= '0;
            s1_a_q          <= '0;
            s1_idx_q        <= '0;
            busy_q          <= 1'b0;
            done_q          <= 1'b0;
            op_continue_q   <= 1'b0;
            terminate_q     <= 1'b0;
            error_q         <= 1'b0;
            pivot_row_idx_q <= '0;
        end else begin
            state_q         <= state_d;
            row_cnt_q       <= row_cnt_d;
            err_q           <= err_d;
            s1_valid_q      <= s1_valid_d;
            s1_elig_q       <= s1_elig_d;
            s1_b_q          <= s1_b_d;
            s1_a_q          <= s1_a_d;
            s1_idx_q        <= s1_idx_d;
            busy_q          <= busy_d;
            done_q          <= done_d;
            op_continue_q   <= op_continue_d;
            terminate_q     <= terminate_d;
            error_q         <= error_d;
            pivot_row_idx_q <= pivot_row_idx_d;
        end
    end

    ratio_cmp_stage #(
        .DATA_W (DATA_W),
        .IDX_W  (IDX_W)
    ) u_cmp (
        .aclk        (aclk),
        .aresetn     (aresetn),
        .clear       (clear_c),
        .valid_in    (s1_valid_q),
        .eligible    (s1_elig_q),
        .b_in        (s1_b_q),
        .a_in        (s1_a_q),
        .idx_in      (s1_idx_q),
        .min_found_c (min_found_c),
        .min_idx_c   (min_idx_c)
    );

    assign busy          = busy_q;
    assign done          = done_q;
    assign op_continue   = op_continue_q;
    assign terminate     = terminate_q;
    assign error         = error_q;
    assign pivot_row_idx = pivot_row_idx_q;

endmodule

// File: tb/tb_pivot_row_ratio_ctrl.sv
// Bench for pivot_row_ratio_ctrl: real-valued min-ratio model plus per-cycle output compare.
module tb_pivot_row_ratio_ctrl;

    localparam int CODE_CONT = 1;
    localparam int CODE_TERM = 2;
    localparam int CODE_ERR  = 3;
    localparam int EPS_RAW   = 1;
    localparam int ONE       = 65536;

    logic        aclk = 1'b0;
    logic        aresetn;
    logic        start, halt;
    logic [31:0] rhs_s_axis_tdata, pivot_col_s_axis_tdata;
    logic        rhs_s_axis_tlast, rhs_s_axis_tvalid, rhs_s_axis_tready;
    logic        pivot_col_s_axis_tlast, pivot_col_s_axis_tvalid, pivot_col_s_axis_tready;
    logic        busy, done, op_continue, terminate, error;
    logic [9:0]  pivot_row_idx;

    pivot_row_ratio_ctrl dut (
        .aclk                    (aclk),
        .aresetn                 (aresetn),
        .start                   (start),
        .halt                    (halt),
        .rhs_s_axis_tdata        (rhs_s_axis_tdata),
        .rhs_s_axis_tlast        (rhs_s_axis_tlast),
        .rhs_s_axis_tvalid       (rhs_s_axis_tvalid),
        .rhs_s_axis_tready       (rhs_s_axis_tready),
        .pivot_col_s_axis_tdata  (pivot_col_s_axis_tdata),
        .pivot_col_s_axis_tlast  (pivot_col_s_axis_tlast),
        .pivot_col_s_axis_tvalid (pivot_col_s_axis_tvalid),
        .pivot_col_s_axis_tready (pivot_col_s_axis_tready),
        .busy                    (busy),
        .done                    (done),
        .op_continue             (op_continue),
        .terminate               (terminate),
        .error                   (error),
        .pivot_row_idx           (pivot_row_idx)
    );

    always #5 aclk = ~aclk;

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;
    bit chk_en = 1'b0;

    int vb[8];
    int va[8];
    bit vrl[8];
    bit vpl[8];

    int q_b[$];
    int q_a[$];
    bit pend_v = 1'b0;
    int pend_due, pend_code, pend_idx;
    int exp_idx = 0;
    int last_hs_cyc = 0;
    int rhs_beats = 0;
    int piv_beats = 0;

    always @(posedge aclk) cyc <= cyc + 1;

    task automatic check(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference: smallest b/a among rows with a > EPS, first occurrence wins
    function automatic void model_eval(output int code, output int idx);
        real best, r;
        bit  found;
        found = 1'b0;
        best  = 0.0;
        idx   = 0;
        for (int i = 0; i < q_b.size(); i++) begin
            if (q_a[i] > EPS_RAW) begin
                r = real'(q_b[i]) / real'(q_a[i]);
                if (!found || r < best) begin
                    found = 1'b1;
                    best  = r;
                    idx   = i;
                end
            end
        end
        code = found ? CODE_CONT : CODE_TERM;
    endfunction

    // Per-cycle compare against the model, then capture of accepted beats
    always @(negedge aclk) begin
        bit exp_done;
        int code, idx;
        if (chk_en) begin
            exp_done = pend_v && (cyc == pend_due);
            check("done", done, exp_done);
            check("op_continue", op_continue, exp_done && pend_code == CODE_CONT);
            check("terminate", terminate, exp_done && pend_code == CODE_TERM);
            check("error", error, exp_done && pend_code == CODE_ERR);
            if (exp_done) begin
                if (pend_code == CODE_CONT) exp_idx = pend_idx;
                else if (pend_code == CODE_TERM) exp_idx = 0;
                pend_v = 1'b0;
            end
            check("pivot_row_idx", pivot_row_idx, exp_idx);
            check("tready_pair", rhs_s_axis_tready, pivot_col_s_axis_tready);
            if (rhs_s_axis_tready)
                check("tready_needs_valid", rhs_s_axis_tvalid && pivot_col_s_axis_tvalid, 1);

            if (halt) begin
                q_b.delete();
                q_a.delete();
            end else begin
                if (rhs_s_axis_tready && rhs_s_axis_tvalid) rhs_beats++;
                if (pivot_col_s_axis_tready && pivot_col_s_axis_tvalid) piv_beats++;
                if (rhs_s_axis_tready && rhs_s_axis_tvalid && pivot_col_s_axis_tvalid) begin
                    q_b.push_back(int'(rhs_s_axis_tdata));
                    q_a.push_back(int'(pivot_col_s_axis_tdata));
                    last_hs_cyc = cyc;
                    if (rhs_s_axis_tlast != pivot_col_s_axis_tlast || (!rhs_s_axis_tlast && q_b.size() == 1024)) begin
                        code = CODE_ERR;
                        idx  = 0;
                    end else begin
                        model_eval(code, idx);
                    end
                    if (rhs_s_axis_tlast || pivot_col_s_axis_tlast || q_b.size() == 1024) begin
                        pend_v    = 1'b1;
                        pend_due  = cyc + 2;
                        pend_code = code;
                        pend_idx  = idx;
                        q_b.delete();
                        q_a.delete();
                    end
                end
            end
        end
    end

    task automatic set_row(input int i, input int b, input int a, input bit rl, input bit pl);
        vb[i] = b; va[i] = a; vrl[i] = rl; vpl[i] = pl;
    endtask

    task automatic drive_rows(input int n, input bit thr);
        int k = 0;
        int budget = 0;
        bit hs;
        while (k < n && budget < 200) begin
            if (!rhs_s_axis_tvalid) rhs_s_axis_tvalid = thr ? 1'($urandom_range(0, 1)) : 1'b1;
            if (!pivot_col_s_axis_tvalid) pivot_col_s_axis_tvalid = thr ? 1'($urandom_range(0, 1)) : 1'b1;
            rhs_s_axis_tdata       = vb[k];
            pivot_col_s_axis_tdata = va[k];
            rhs_s_axis_tlast       = vrl[k];
            pivot_col_s_axis_tlast = vpl[k];
            @(negedge aclk);
            hs = rhs_s_axis_tready && rhs_s_axis_tvalid;
            @(posedge aclk);
            #1;
            if (hs) begin
                k++;
                rhs_s_axis_tvalid       = 1'b0;
                pivot_col_s_axis_tvalid = 1'b0;
            end
            budget++;
        end
        check("rows_accepted", k, n);
        rhs_s_axis_tvalid       = 1'b0;
        pivot_col_s_axis_tvalid = 1'b0;
        rhs_s_axis_tlast        = 1'b0;
        pivot_col_s_axis_tlast  = 1'b0;
    endtask

    task automatic do_run(input int n, input bit thr);
        @(posedge aclk); #1;
        start = 1'b1;
        @(posedge aclk); #1;
        start = 1'b0;
        drive_rows(n, thr);
    endtask

    // Waits (bounded) for the done pulse and checks it against hand-computed values
    task automatic expect_result(input string name, input bit e_op, input bit e_term,
                                 input bit e_err, input int e_idx);
        bit seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge aclk);
            if (done) begin
                seen = 1'b1;
                check({name, "_op"}, op_continue, e_op);
                check({name, "_term"}, terminate, e_term);
                check({name, "_err"}, error, e_err);
                check({name, "_idx"}, pivot_row_idx, e_idx);
                check({name, "_latency"}, cyc - last_hs_cyc, 2);
                check({name, "_busy_low"}, busy, 0);
            end
        end
        check({name, "_done_seen"}, seen, 1);
    endtask

    initial begin
        int rb0, pb0;
        aresetn = 1'b0;
        start = 1'b0; halt = 1'b0;
        rhs_s_axis_tdata = '0; rhs_s_axis_tlast = 1'b0; rhs_s_axis_tvalid = 1'b0;
        pivot_col_s_axis_tdata = '0; pivot_col_s_axis_tlast = 1'b0; pivot_col_s_axis_tvalid = 1'b0;
        repeat (3) @(posedge aclk);
        #1;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_op", op_continue, 0);
        check("rst_term", terminate, 0);
        check("rst_err", error, 0);
        check("rst_idx", pivot_row_idx, 0);
        check("rst_tready", rhs_s_axis_tready | pivot_col_s_axis_tready, 0);
        aresetn = 1'b1;
        chk_en  = 1'b1;

        // ratios 2,2,1 -> row 2
        set_row(0, 4 * ONE, 2 * ONE, 0, 0);
        set_row(1, 6 * ONE, 3 * ONE, 0, 0);
        set_row(2, 3 * ONE, 3 * ONE, 1, 1);
        do_run(3, 0);
        check("t1_busy_finish", busy, 1);
        expect_result("basic", 1, 0, 0, 2);

        // equal ratios -> lower index kept
        set_row(0, 6 * ONE, 3 * ONE, 0, 0);
        set_row(1, 4 * ONE, 2 * ONE, 1, 1);
        do_run(2, 0);
        expect_result("tie", 1, 0, 0, 0);

        set_row(0, 1 * ONE, 0, 0, 0);
        set_row(1, 2 * ONE, -ONE, 0, 0);
        set_row(2, 3 * ONE, 0, 1, 1);
        do_run(3, 0);
        expect_result("no_pos", 0, 1, 0, 0);

        set_row(0, 1 * ONE, EPS_RAW, 0, 0);
        set_row(1, 2 * ONE, EPS_RAW, 0, 0);
        set_row(2, 3 * ONE, EPS_RAW, 1, 1);
        do_run(3, 0);
        expect_result("at_eps", 0, 1, 0, 0);

        set_row(0, 4 * ONE, 2 * ONE, 0, 0);
        set_row(1, 6 * ONE, 3 * ONE, 0, 0);
        set_row(2, 3 * ONE, 3 * ONE, 1, 1);
        rb0 = rhs_beats; pb0 = piv_beats;
        do_run(3, 1);
        expect_result("throttled", 1, 0, 0, 2);
        check("rhs_beats", rhs_beats - rb0, 3);
        check("piv_beats", piv_beats - pb0, 3);

        // rhs tlast without pivot tlast; ratio 1 row must not leak into the held index
        set_row(0, 1 * ONE, 1 * ONE, 0, 0);
        set_row(1, 1 * ONE, 1 * ONE, 1, 0);
        do_run(2, 0);
        expect_result("mismatch", 0, 0, 1, 2);

        // aborted run holds a ratio-1 minimum at row 0; the fresh run must not see it
        set_row(0, 1 * ONE, 1 * ONE, 0, 0);
        set_row(1, 1 * ONE, 1 * ONE, 0, 0);
        do_run(2, 0);
        halt = 1'b1;
        rhs_s_axis_tvalid = 1'b1;
        pivot_col_s_axis_tvalid = 1'b1;
        @(negedge aclk);
        check("halt_tready", rhs_s_axis_tready | pivot_col_s_axis_tready, 0);
        @(posedge aclk); #1;
        halt = 1'b0;
        rhs_s_axis_tvalid = 1'b0;
        pivot_col_s_axis_tvalid = 1'b0;
        @(negedge aclk);
        check("halt_busy", busy, 0);
        set_row(0, 8 * ONE, 2 * ONE, 0, 0);
        set_row(1, 6 * ONE, 2 * ONE, 0, 0);
        set_row(2, 9 * ONE, 1 * ONE, 1, 1);
        do_run(3, 0);
        expect_result("after_halt", 1, 0, 0, 1);

        // start and halt together: stays idle
        @(posedge aclk); #1;
        start = 1'b1; halt = 1'b1;
        @(posedge aclk); #1;
        start = 1'b0; halt = 1'b0;
        @(negedge aclk);
        check("start_halt_busy", busy, 0);

        // async reset mid-run
        set_row(0, 1 * ONE, 1 * ONE, 0, 0);
        do_run(1, 0);
        rhs_s_axis_tvalid = 1'b1;
        pivot_col_s_axis_tvalid = 1'b1;
        #2;
        q_b.delete();
        q_a.delete();
        pend_v  = 1'b0;
        exp_idx = 0;
        aresetn = 1'b0;
        #1;
        check("arst_busy", busy, 0);
        check("arst_idx", pivot_row_idx, 0);
        check("arst_tready", rhs_s_axis_tready | pivot_col_s_axis_tready, 0);
        check("arst_flags", done | op_continue | terminate | error, 0);
        rhs_s_axis_tvalid = 1'b0;
        pivot_col_s_axis_tvalid = 1'b0;
        @(posedge aclk); #1;
        aresetn = 1'b1;

        set_row(0, 4 * ONE, 2 * ONE, 0, 0);
        set_row(1, 6 * ONE, 3 * ONE, 0, 0);
        set_row(2, 3 * ONE, 3 * ONE, 1, 1);
        do_run(3, 0);
        expect_result("recover", 1, 0, 0, 2);

        repeat (3) @(posedge aclk);
        check("pending_drained", pend_v, 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/pivot_row_ratio_ctrl.md
Name: pivot_row_ratio_ctrl

Overview:
Sequences the simplex ratio test that selects the pivot row. Consumes the RHS column and the pivot column as two lock-stepped AXI-Stream slaves, one row per beat. Tracks the minimum ratio RHS/pivot over rows whose pivot entry exceeds EPS, then reports the winning row index or reports unboundedness to the top-level LP sequencer. Ratios are compared by cross-multiplication, so no divider is needed.

Parameters:
DATA_W, 32, width of signed Q16.16 tableau entries
IDX_W, 10, row index width; at most 2**IDX_W rows
EPS, 32'sd1, minimum pivot entry (raw Q16.16 value) for a row to be eligible

Ports:
aclk  in  1  clock
aresetn  in  1  reset, asynchronous, active-low
start  in  1  begin one ratio test; only sampled in IDLE
halt  in  1  synchronous abort; returns the block to IDLE
rhs_s_axis_tdata  in  DATA_W  RHS entry b_i
rhs_s_axis_tlast  in  1  last row
rhs_s_axis_tvalid  in  1  beat valid
rhs_s_axis_tready  out  1  beat accepted
pivot_col_s_axis_tdata  in  DATA_W  pivot column entry a_i
pivot_col_s_axis_tlast  in  1  last row
pivot_col_s_axis_tvalid  in  1  beat valid
pivot_col_s_axis_tready  out  1  beat accepted
busy  out  1  high in RUN and FINISH
done  out  1  one-cycle pulse at end of test
op_continue  out  1  one-cycle pulse with done; a pivot row was found
terminate  out  1  one-cycle pulse with done; problem is unbounded (no eligible row)
error  out  1  one-cycle pulse with done; tlast mismatch or row overflow
pivot_row_idx  out  IDX_W  winning row index; held until the next start

Behaviour:
- Reset: all outputs 0, state IDLE, internal minimum registers cleared.
- States: IDLE -> RUN on start. RUN -> FINISH after the handshake carrying tlast, or on an error. FINISH -> IDLE after one cycle, during which the stage-2 update completes. done and exactly one of op_continue/terminate/error pulse on the FINISH->IDLE edge.
- Handshake: both treadys = (state==RUN) & rhs_tvalid & pivot_col_tvalid, so the two streams are consumed in lockstep. tvalid never waits on tready. No beats are accepted outside RUN.
- Row counter: cleared on start, incremented per handshake; row i = i-th beat since start.
- Stage 1 (handshake cycle): register b_i, a_i, i, and eligible = (a_i > EPS), signed compare.
- Stage 2 (next cycle): if eligible and (no candidate yet, or b_i*a_min < b_min*a_i), update (b_min, a_min, idx_min). Products are signed 2*DATA_W. Strict less-than, so ties keep the lower index (Bland's rule).
- Latency: done is asserted 2 cycles after the tlast handshake.
- tlast mismatch (exactly one tlast set on a handshake): the beat is consumed, then FINISH with error; pivot_row_idx is unchanged.
- Row count reaching 2**IDX_W without tlast: error, same handling as a mismatch.
- No eligible row by tlast: terminate=1, pivot_row_idx=0.
- halt: highest priority in any state. Next state IDLE, treadys drop the same cycle, no done pulse, pivot_row_idx unchanged.
- start while busy: ignored. start and halt in the same cycle: halt wins and the block stays in IDLE.

Decomposition:
- Shared package lp_pkg: Q16.16 typedef, DATA_W/IDX_W defaults, state enum, result code constants (CONT/TERM/ERR). The top-level LP sequencer reuses these.
- One sub-module: ratio_cmp_stage, which holds stage-2 cross-multiply, compare, and the min registers. Valid-in, clear, eligible flag in; min outputs out.
- The FSM, row counter and handshake logic stay in the top module.

Test Plan:
- Rows b=[4,6,3], a=[2,3,3] (integers in Q16.16), tlast on row 2 -> ratios 2,2,1; done pulses 2 cycles after the last handshake with op_continue=1, pivot_row_idx=2.
- Tie: b=[6,4], a=[3,2] -> equal ratios 2; pivot_row_idx=0 (lower index kept).
- a=[0,-1,0] -> terminate=1, op_continue=0, pivot_row_idx=0. Also a=EPS on every row -> terminate.
- Randomly throttled tvalid on each stream independently -> treadys only asserted when both are valid; result matches the unthrottled run; beat counts on the two streams are equal.
- rhs tlast set on row 1 with pivot_col tlast not set -> error=1 two cycles later; previous pivot_row_idx retained.
- halt mid-RUN after 2 rows, then start with a fresh 3-row stream -> no done pulse for the aborted run; the new run gives the correct index with no carry-over of the earlier minimum. Asserting aresetn low mid-RUN -> all outputs 0 immediately.
